// File: rtl/param_loader_pkg.sv
// Shared constants, state encoding and payload unpacking for the parameter frame loader.
package param_loader_pkg;

    localparam int FRAME_PAYLOAD_LEN = 19;
    localparam int PAYLOAD_BITS      = FRAME_PAYLOAD_LEN * 8;
    localparam int IDX_W             = 5;

    // Byte offsets of each big-endian field inside the payload.
    // The fields fill bytes 0..17; byte 18 is a spare that is only summed into the checksum.
    localparam int OFS_PER      = 0;
    localparam int OFS_P1WID    = 4;
    localparam int OFS_DEL      = 6;
    localparam int OFS_P2WID    = 8;
    localparam int OFS_NUT_W    = 10;
    localparam int OFS_NUT_D    = 11;
    localparam int OFS_CP       = 13;
    localparam int OFS_P_BL     = 14;
    localparam int OFS_P_BL_OFF = 15;
    localparam int OFS_BL       = 17;

    localparam logic [7:0] ACK_CODE = 8'h06;
    localparam logic [7:0] NAK_CODE = 8'h15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [7:0]  nut_w;
        logic [15:0] nut_d;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic        bl;
    } params_t;

    localparam params_t PARAMS_RESET = '{
        per:      32'd20000,
        p1wid:    16'd30,
        del:      16'd200,
        p2wid:    16'd60,
        nut_w:    8'd0,
        nut_d:    16'd0,
        cp:       8'd1,
        p_bl:     8'd50,
        p_bl_off: 16'd100,
        bl:       1'b1
    };

    // Byte 0 of the payload sits in the most significant byte of the flat vector.
    function automatic logic [7:0] payload_byte(input logic [PAYLOAD_BITS-1:0] v, input int ofs);
        return v[PAYLOAD_BITS-1-8*ofs -: 8];
    endfunction

    function automatic params_t unpack_payload(input logic [PAYLOAD_BITS-1:0] v);
        params_t    p;
        logic [7:0] bl_byte;
        p.per      = {payload_byte(v, OFS_PER), payload_byte(v, OFS_PER+1),
                      payload_byte(v, OFS_PER+2), payload_byte(v, OFS_PER+3)};
        p.p1wid    = {payload_byte(v, OFS_P1WID), payload_byte(v, OFS_P1WID+1)};
        p.del      = {payload_byte(v, OFS_DEL), payload_byte(v, OFS_DEL+1)};
        p.p2wid    = {payload_byte(v, OFS_P2WID), payload_byte(v, OFS_P2WID+1)};
        p.nut_w    = payload_byte(v, OFS_NUT_W);
        p.nut_d    = {payload_byte(v, OFS_NUT_D), payload_byte(v, OFS_NUT_D+1)};
        p.cp       = payload_byte(v, OFS_CP);
        p.p_bl     = payload_byte(v, OFS_P_BL);
        p.p_bl_off = {payload_byte(v, OFS_P_BL_OFF), payload_byte(v, OFS_P_BL_OFF+1)};
        bl_byte    = payload_byte(v, OFS_BL);
        p.bl       = bl_byte[0];
        return p;
    endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Idle-gap watchdog: counts cycles without an accepted byte while enabled, flags expiry at TIMEOUT.
module byte_gap_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = 17;

    logic [W-1:0] count_reg;

    // Expiry is flagged on the TIMEOUT-th consecutive idle cycle.
    assign expired = enable && (count_reg == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear || !enable) begin
            count_reg <= '0;
        end else if (!expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/param_frame_loader.sv
// Framed UART byte stream to pulse-sequencer parameters, committed atomically after checksum.
// Optional status reporting back to the PC is enabled with `define PARAM_LOADER_ACK_EN.
module param_frame_loader
    import param_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [7:0]  nut_w,
    output logic [15:0] nut_d,
    output logic [7:0]  cp,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic        bl,
    output logic        params_upd,
    output logic [7:0]  err_cnt
`ifdef PARAM_LOADER_ACK_EN
    ,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
`endif
);
    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [7:0]              sum_reg, sum_next;
    params_t                 params_reg;
    logic                    params_upd_reg;
    logic [7:0]              err_cnt_reg;
    logic [PAYLOAD_BITS-1:0] shadow_flat;

    logic load;
    logic commit;
    logic fail;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign timer_enable = (state_reg != IDLE);

    byte_gap_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // One holding register per payload byte; never visible until a commit.
    generate
        for (genvar gi = 0; gi < FRAME_PAYLOAD_LEN; gi++) begin : g_shadow
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (load && idx_reg == IDX_W'(gi)) begin
                    byte_reg <= rx_data;
                end
            end
            assign shadow_flat[PAYLOAD_BITS-1-8*gi -: 8] = byte_reg;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        sum_next    = sum_reg;
        load        = 1'b0;
        commit      = 1'b0;
        fail        = 1'b0;
        timer_clear = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next  = PAYLOAD;
                    idx_next    = '0;
                    sum_next    = '0;
                    timer_clear = 1'b1;
                end
            end
            PAYLOAD: begin
                // A byte in the expiry cycle still counts: the received byte takes priority.
                if (rx_valid) begin
                    load        = 1'b1;
                    sum_next    = sum_reg + rx_data;
                    timer_clear = 1'b1;
                    if (idx_reg == IDX_W'(FRAME_PAYLOAD_LEN - 1)) begin
                        state_next = CHECK;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next = IDLE;
                    fail       = 1'b1;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    timer_clear = 1'b1;
                    state_next  = IDLE;
                    if (rx_data == sum_reg) begin
                        commit = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_next = IDLE;
                    fail       = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            sum_reg        <= '0;
            params_reg     <= PARAMS_RESET;
            params_upd_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            sum_reg        <= sum_next;
            params_upd_reg <= commit;
            if (commit) begin
                params_reg <= unpack_payload(shadow_flat);
            end
            if (fail && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign per        = params_reg.per;
    assign p1wid      = params_reg.p1wid;
    assign del        = params_reg.del;
    assign p2wid      = params_reg.p2wid;
    assign nut_w      = params_reg.nut_w;
    assign nut_d      = params_reg.nut_d;
    assign cp         = params_reg.cp;
    assign p_bl       = params_reg.p_bl;
    assign p_bl_off   = params_reg.p_bl_off;
    assign bl         = params_reg.bl;
    assign params_upd = params_upd_reg;
    assign err_cnt    = err_cnt_reg;

`ifdef PARAM_LOADER_ACK_EN
    logic [7:0] tx_data_reg;
    logic       tx_valid_reg;

    // Single-entry status slot: the most recent outcome replaces anything not yet taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
        end else if (commit) begin
            tx_data_reg  <= ACK_CODE;
            tx_valid_reg <= 1'b1;
        end else if (fail) begin
            tx_data_reg  <= NAK_CODE;
            tx_valid_reg <= 1'b1;
        end else if (tx_ready && tx_valid_reg) begin
            tx_valid_reg <= 1'b0;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
`endif

endmodule

// File: tb/tb_param_frame_loader.sv
// Self-checking bench for param_frame_loader: table frames, corner sequences and random frames.
// Status-reporting checks are included when PARAM_LOADER_ACK_EN is defined.
module tb_param_frame_loader;

    localparam int TO = 50000;
    localparam logic [136:0] DEF_VEC = {32'd20000, 16'd30, 16'd200, 16'd60, 8'd0,
                                        16'd0, 8'd1, 8'd50, 16'd100, 1'b1};

    // Payload as transmitted: first field is the first byte on the wire.
    typedef struct packed {
        logic [31:0] per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [7:0]  nut_w;
        logic [15:0] nut_d;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic [7:0]  bl_byte;
        logic [7:0]  pad;
    } fields_t;

    typedef struct {
        fields_t    f;
        logic [7:0] delta;
        int         junk;
        logic       exp_upd;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
    logic        params_upd;
    logic [7:0]  err_cnt;
`ifdef PARAM_LOADER_ACK_EN
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`endif

    param_frame_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .per        (per),
        .p1wid      (p1wid),
        .del        (del),
        .p2wid      (p2wid),
        .nut_w      (nut_w),
        .nut_d      (nut_d),
        .cp         (cp),
        .p_bl       (p_bl),
        .p_bl_off   (p_bl_off),
        .bl         (bl),
        .params_upd (params_upd),
        .err_cnt    (err_cnt)
`ifdef PARAM_LOADER_ACK_EN
        ,
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [136:0] dut_vec;
    assign dut_vec = {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl};

    int           n_vec;
    int           n_bad;
    int           upd_seen;
    int           frame_no;
    logic [136:0] model_out;
    int           model_err;
    int           model_upd;
    vec_t         tbl[4];

    function automatic logic [136:0] exp_vec(input fields_t f);
        return {f.per, f.p1wid, f.del, f.p2wid, f.nut_w, f.nut_d, f.cp, f.p_bl, f.p_bl_off, f.bl_byte[0]};
    endfunction

    function automatic fields_t rand_fields();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[151:0];
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; every cycle passes through here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (params_upd) upd_seen++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic void model_error();
        if (model_err < 255) model_err++;
    endfunction

    task automatic send_frame(input fields_t f, input logic [7:0] delta, input int junk,
                              input int gap, input logic rand_junk, output logic upd);
        logic [151:0] raw;
        logic [7:0]   b;
        logic [7:0]   sum;
        logic         ok;
        raw = f;
        sum = 8'h00;
        for (int j = 0; j < junk; j++) begin
            b = rand_junk ? 8'($urandom_range(0, 255)) : 8'h00;
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, gap);
        end
        send_byte(8'hA5, gap);
        for (int i = 0; i < 19; i++) begin
            b   = raw[151-8*i -: 8];
            sum = sum + b;
            send_byte(b, gap);
            check("hold_during_frame", 160'(dut_vec), 160'(model_out));
        end
        ok       = (delta == 8'h00);
        rx_data  = sum + delta;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        upd      = params_upd;
        check("upd_latency", 160'(params_upd), 160'(ok));
        if (ok) begin
            model_out = exp_vec(f);
            model_upd++;
        end else begin
            model_error();
        end
        check("params", 160'(dut_vec), 160'(model_out));
        check("err_cnt", 160'(err_cnt), 160'(model_err));
        check("upd_count", 160'(upd_seen), 160'(model_upd));
        $display("frame %0d: chk_ok=%0d params_upd=%0d err_cnt=%0d", frame_no, ok, upd, err_cnt);
        frame_no++;
        repeat (gap) tick();
    endtask

    initial begin
        logic upd;
        fields_t f;

        n_vec     = 0;
        n_bad     = 0;
        upd_seen  = 0;
        frame_no  = 0;
        model_out = DEF_VEC;
        model_err = 0;
        model_upd = 0;
        reset_n   = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
`ifdef PARAM_LOADER_ACK_EN
        tx_ready  = 1'b0;
`endif

        tbl[0].f = '{per: 32'd1000, p1wid: 16'd40, del: 16'd300, p2wid: 16'd80, nut_w: 8'd5,
                     nut_d: 16'd12, cp: 8'd3, p_bl: 8'd20, p_bl_off: 16'd500, bl_byte: 8'd0, pad: 8'd0};
        tbl[0].delta = 8'd1;  tbl[0].junk = 0; tbl[0].exp_upd = 1'b0;
        tbl[1].f = tbl[0].f;
        tbl[1].delta = 8'd0;  tbl[1].junk = 0; tbl[1].exp_upd = 1'b1;
        tbl[2].f = '{per: 32'hA5A5_00A5, p1wid: 16'hA5A5, del: 16'h00A5, p2wid: 16'h1234, nut_w: 8'hA5,
                     nut_d: 16'hA500, cp: 8'hA5, p_bl: 8'h01, p_bl_off: 16'hBEEF, bl_byte: 8'hA5, pad: 8'hA5};
        tbl[2].delta = 8'd0;  tbl[2].junk = 1; tbl[2].exp_upd = 1'b1;
        tbl[3].f = '{per: 32'hFFFF_FFFF, p1wid: 16'hFFFF, del: 16'hFFFF, p2wid: 16'hFFFF, nut_w: 8'hFF,
                     nut_d: 16'hFFFF, cp: 8'hFF, p_bl: 8'hFF, p_bl_off: 16'hFFFF, bl_byte: 8'hFE, pad: 8'hFF};
        tbl[3].delta = 8'd0;  tbl[3].junk = 0; tbl[3].exp_upd = 1'b1;

        repeat (3) tick();
        reset_n = 1'b1;
        check("reset_params", 160'(dut_vec), 160'(DEF_VEC));
        check("reset_err_cnt", 160'(err_cnt), 160'(0));
        check("reset_upd", 160'(params_upd), 160'(0));

        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].f, tbl[i].delta, tbl[i].junk, 0, 1'b0, upd);
            check("tbl_upd", 160'(upd), 160'(tbl[i].exp_upd));
        end

        // Stalled frame: SYNC plus five bytes, then exactly TIMEOUT idle cycles.
        send_byte(8'hA5, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 0);
        repeat (TO - 1) tick();
        check("err_before_timeout", 160'(err_cnt), 160'(model_err));
        tick();
        model_error();
        check("err_at_timeout", 160'(err_cnt), 160'(model_err));
        check("timeout_no_commit", 160'(dut_vec), 160'(model_out));
        $display("timeout: err_cnt=%0d", err_cnt);
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);

        // Back-to-back frames with SYNC right after CHK.
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);

`ifdef PARAM_LOADER_ACK_EN
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);
        check("ack_valid", 160'(tx_valid), 160'(1));
        check("ack_data", 160'(tx_data), 160'(8'h06));
        repeat (3) tick();
        check("ack_held", 160'(tx_valid), 160'(1));
        send_frame(rand_fields(), 8'd7, 0, 0, 1'b0, upd);
        check("nak_valid", 160'(tx_valid), 160'(1));
        check("nak_data", 160'(tx_data), 160'(8'h15));
        tx_ready = 1'b1;
        tick();
        check("tx_drop", 160'(tx_valid), 160'(0));
        tx_ready = 1'b0;
        $display("ack: tx_valid=%0d tx_data=%h", tx_valid, tx_data);
`endif

        for (int n = 0; n < 40; n++) begin
            f = rand_fields();
            send_frame(f, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                       $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, upd);
        end

        // Reset for one clock in the middle of a payload.
        send_byte(8'hA5, 0);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 0);
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        model_out = DEF_VEC;
        model_err = 0;
        check("midreset_params", 160'(dut_vec), 160'(DEF_VEC));
        check("midreset_err_cnt", 160'(err_cnt), 160'(0));
        check("midreset_upd", 160'(params_upd), 160'(0));
        $display("mid-frame reset: err_cnt=%0d", err_cnt);
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);
        check("post_reset_commit", 160'(upd), 160'(1));

        // Drive the error counter into saturation.
        for (int n = 0; n < 260; n++) begin
            send_frame(rand_fields(), 8'd1, 0, 0, 1'b0, upd);
        end
        check("err_saturated", 160'(err_cnt), 160'(255));
        send_frame(rand_fields(), 8'd0, 0, 0, 1'b0, upd);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
